ca_code_gen: RTL and testbench



---
 rtl/gps_pkg.sv | 53 +++++
 rtl/ca_lfsr_pair.sv | 49 ++++
 rtl/ca_code_gen.sv | 154 +++++++++++++++
 tb/tb_ca_code_gen.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/gps_pkg.sv
// Shared GPS L1 C/A constants: code geometry, chip-rate divider sizing,
// generator FSM encodings, LFSR reload value and the PRN G2 tap-pair table.
// Pure declarations; no logic or clocking lives here.
package gps_pkg;

  // System clocks per chip (16.368 MHz / 1.023 Mchip/s) and chips per epoch.
  localparam int CLKS_PER_CHIP = 16;
  localparam int CODE_LEN      = 1023;

  localparam int DIV_W = $clog2(CLKS_PER_CHIP);
  localparam int IDX_W = 10;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_CHIP - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CODE_LEN - 1);
  localparam logic [IDX_W-1:0] PHASE_ALT = IDX_W'(CODE_LEN);  // 1023 aliases chip 0

  localparam logic [10:1] LFSR_INIT = 10'h3FF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_SLEW = 3'b010,
    ST_RUN  = 3'b100
  } ca_state_t;

  // G2 stage pair whose XOR forms the delayed G2 sequence for one PRN.
  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
  } tap_pair_t;

  // Indexed by n_sat (PRN - 1).
  localparam tap_pair_t PRN_TAPS [32] = '{
    '{4'd2, 4'd6},  '{4'd3, 4'd7},  '{4'd4, 4'd8},  '{4'd5, 4'd9},
    '{4'd1, 4'd9},  '{4'd2, 4'd10}, '{4'd1, 4'd8},  '{4'd2, 4'd9},
    '{4'd3, 4'd10}, '{4'd2, 4'd3},  '{4'd3, 4'd4},  '{4'd5, 4'd6},
    '{4'd6, 4'd7},  '{4'd7, 4'd8},  '{4'd8, 4'd9},  '{4'd9, 4'd10},
    '{4'd1, 4'd4},  '{4'd2, 4'd5},  '{4'd3, 4'd6},  '{4'd4, 4'd7},
    '{4'd5, 4'd8},  '{4'd6, 4'd9},  '{4'd1, 4'd3},  '{4'd4, 4'd6},
    '{4'd5, 4'd7},  '{4'd6, 4'd8},  '{4'd7, 4'd9},  '{4'd8, 4'd10},
    '{4'd1, 4'd6},  '{4'd2, 4'd7},  '{4'd3, 4'd8},  '{4'd4, 4'd9}
  };

  // G1 = 1 + x^3 + x^10; stage 1 takes the feedback, stage 10 is the output.
  function automatic logic [10:1] g1_step(input logic [10:1] g);
    return {g[9:1], g[3] ^ g[10]};
  endfunction

  // G2 = 1 + x^2 + x^3 + x^6 + x^8 + x^9 + x^10.
  function automatic logic [10:1] g2_step(input logic [10:1] g);
    return {g[9:1], g[2] ^ g[3] ^ g[6] ^ g[8] ^ g[9] ^ g[10]};
  endfunction

endpackage

// File: rtl/ca_lfsr_pair.sv
// G1/G2 LFSR pair with PRN tap select; chip_o is the Gold chip for the current state.
// Latency: chip_o is combinational from the registered LFSR state; load/step act next clock.
// No backpressure: load has priority over step, otherwise the state holds.
module ca_lfsr_pair
  import gps_pkg::*;
(
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [4:0] n_sat_i,
  output logic       chip_o
);

  logic [10:1] g1_q, g1_d;
  logic [10:1] g2_q, g2_d;
  tap_pair_t   taps;

  // Next LFSR state: reload to all-ones, advance one chip, or hold.
  always_comb begin
    g1_d = g1_q;
    g2_d = g2_q;
    if (load_i) begin
      g1_d = LFSR_INIT;
      g2_d = LFSR_INIT;
    end else if (step_i) begin
      g1_d = g1_step(g1_q);
      g2_d = g2_step(g2_q);
    end
  end

  // LFSR state registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      g1_q <= LFSR_INIT;
      g2_q <= LFSR_INIT;
    end else begin
      g1_q <= g1_d;
      g2_q <= g2_d;
    end
  end

  // Gold chip: G1 output XOR the PRN-specific pair of G2 stages.
  always_comb begin
    taps   = PRN_TAPS[n_sat_i];
    chip_o = g1_q[10] ^ g2_q[taps.a] ^ g2_q[taps.b];
  end

endmodule

// File: rtl/ca_code_gen.sv
// GPS L1 C/A Gold-code generator: reload / phase-slew / run FSM around a G1/G2 LFSR pair.
// Latency: first chip strobe 2 + phase clocks after a reload trigger is sampled.
// No backpressure: free-running chip stream, one chip per CLKS_PER_CHIP clocks while in RUN.
module ca_code_gen
  import gps_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        enable_in,
  input  logic [4:0]  n_sat_in,
  input  logic [15:0] ca_phase_in,
  output logic        ca_chip_out,
  output logic        chip_strobe_out,
  output logic        epoch_out,
  output logic        code_valid_out
);

  ca_state_t         state_q;
  logic              enable_q;
  logic [4:0]        n_sat_q;
  logic [IDX_W-1:0]  phase_q;
  logic [IDX_W-1:0]  slew_cnt_q;
  logic [IDX_W-1:0]  chip_idx_q;
  logic [DIV_W-1:0]  div_cnt_q;
  logic              ca_chip_q;
  logic              strobe_q;
  logic              epoch_q;
  logic              valid_q;

  logic              en_rise;
  logic              cfg_change;
  logic              reload;
  logic [IDX_W-1:0]  phase_eff;
  logic              lfsr_load;
  logic              lfsr_step;
  logic              lfsr_chip;
  logic              phase_hi_unused;

  // Only ten phase bits are meaningful; the upper field is don't-care.
  assign phase_hi_unused = ^ca_phase_in[15:10];

  assign en_rise    = enable_in & ~enable_q;
  assign cfg_change = (n_sat_in != n_sat_q) || (ca_phase_in[IDX_W-1:0] != phase_q);
  // Config changes only restart an active generator; IDLE waits for a fresh enable edge.
  assign reload     = enable_in & (en_rise | ((state_q != ST_IDLE) & cfg_change));
  assign phase_eff  = (ca_phase_in[IDX_W-1:0] == PHASE_ALT) ? '0 : ca_phase_in[IDX_W-1:0];

  // LFSR control: reload on disable/trigger/code wrap, step during slew and at chip end.
  always_comb begin
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    if (!enable_in || reload) begin
      lfsr_load = 1'b1;
    end else begin
      case (state_q)
        ST_SLEW: lfsr_step = (slew_cnt_q != '0);
        ST_RUN: begin
          if (div_cnt_q == DIV_LAST) begin
            if (chip_idx_q == IDX_LAST) lfsr_load = 1'b1;
            else                        lfsr_step = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  ca_lfsr_pair u_lfsr (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .load_i  (lfsr_load),
    .step_i  (lfsr_step),
    .n_sat_i (n_sat_q),
    .chip_o  (lfsr_chip)
  );

  // Generator FSM, counters and registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      // Seeded high so an enable already asserted at reset release is not a rising edge.
      enable_q   <= 1'b1;
      n_sat_q    <= '0;
      phase_q    <= '0;
      slew_cnt_q <= '0;
      chip_idx_q <= '0;
      div_cnt_q  <= '0;
      ca_chip_q  <= 1'b0;
      strobe_q   <= 1'b0;
      epoch_q    <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      enable_q <= enable_in;
      strobe_q <= 1'b0;
      epoch_q  <= 1'b0;
      if (!enable_in) begin
        state_q    <= ST_IDLE;
        slew_cnt_q <= '0;
        chip_idx_q <= '0;
        div_cnt_q  <= '0;
        ca_chip_q  <= 1'b0;
        valid_q    <= 1'b0;
      end else if (reload) begin
        // Latch the new code selection and restart the slew from chip 0.
        n_sat_q    <= n_sat_in;
        phase_q    <= ca_phase_in[IDX_W-1:0];
        slew_cnt_q <= phase_eff;
        chip_idx_q <= '0;
        div_cnt_q  <= '0;
        ca_chip_q  <= 1'b0;
        valid_q    <= 1'b0;
        state_q    <= ST_SLEW;
      end else begin
        case (state_q)
          ST_IDLE: ;
          ST_SLEW: begin
            if (slew_cnt_q == '0) begin
              state_q   <= ST_RUN;
              div_cnt_q <= '0;
              valid_q   <= 1'b1;
            end else begin
              slew_cnt_q <= slew_cnt_q - IDX_W'(1);
              chip_idx_q <= chip_idx_q + IDX_W'(1);
            end
          end
          ST_RUN: begin
            if (div_cnt_q == '0) begin
              strobe_q  <= 1'b1;
              ca_chip_q <= lfsr_chip;
              epoch_q   <= (chip_idx_q == '0);
            end
            if (div_cnt_q == DIV_LAST) begin
              div_cnt_q  <= '0;
              chip_idx_q <= (chip_idx_q == IDX_LAST) ? '0 : chip_idx_q + IDX_W'(1);
            end else begin
              div_cnt_q <= div_cnt_q + DIV_W'(1);
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            ca_chip_q <= 1'b0;
            valid_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ca_chip_out     = ca_chip_q;
  assign chip_strobe_out = strobe_q;
  assign epoch_out       = epoch_q;
  assign code_valid_out  = valid_q;

endmodule

// File: tb/tb_ca_code_gen.sv
`timescale 1ns/1ps
module tb_ca_code_gen;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        enable_in = 1'b0;
  logic [4:0]  n_sat_in = '0;
  logic [15:0] ca_phase_in = '0;
  logic        ca_chip_out;
  logic        chip_strobe_out;
  logic        epoch_out;
  logic        code_valid_out;
  logic [3:0]  outs;

  int total = 0;
  int bad   = 0;

  ca_code_gen dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .enable_in       (enable_in),
    .n_sat_in        (n_sat_in),
    .ca_phase_in     (ca_phase_in),
    .ca_chip_out     (ca_chip_out),
    .chip_strobe_out (chip_strobe_out),
    .epoch_out       (epoch_out),
    .code_valid_out  (code_valid_out)
  );

  always #5 clk_in = ~clk_in;

  assign outs = {ca_chip_out, chip_strobe_out, epoch_out, code_valid_out};

  // Hard stop if anything stalls far beyond the expected run length.
  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference Gold code built straight from the ICD LFSR description.
  int tap_a [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
  int tap_b [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};
  bit gold [1023];

  task automatic build_gold(input int sat);
    bit g1 [1:10];
    bit g2 [1:10];
    bit f1, f2;
    for (int j = 1; j <= 10; j++) begin
      g1[j] = 1'b1;
      g2[j] = 1'b1;
    end
    for (int k = 0; k < 1023; k++) begin
      gold[k] = g1[10] ^ g2[tap_a[sat]] ^ g2[tap_b[sat]];
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      for (int j = 10; j > 1; j--) begin
        g1[j] = g1[j-1];
        g2[j] = g2[j-1];
      end
      g1[1] = f1;
      g2[1] = f2;
    end
  endtask

  // Captured stream and timing observations.
  bit cap_chip [1024];
  int cap_got, cap_lat, cap_vld_rise, cap_gap_bad, cap_ep_first, cap_ep_cnt;

  task automatic capture(input int n);
    int cyc;
    int last;
    cyc = 0;
    last = 0;
    cap_got = 0; cap_lat = -1; cap_vld_rise = -1;
    cap_gap_bad = 0; cap_ep_first = -1; cap_ep_cnt = 0;
    while (cap_got < n && cyc < n * 16 + 2000) begin
      @(negedge clk_in);
      cyc++;
      if (code_valid_out && cap_vld_rise < 0) cap_vld_rise = cyc;
      if (epoch_out && !chip_strobe_out) cap_gap_bad++;
      if (chip_strobe_out) begin
        if (cap_got == 0) cap_lat = cyc;
        else if (cyc - last != 16) cap_gap_bad++;
        cap_chip[cap_got] = ca_chip_out;
        if (epoch_out) begin
          cap_ep_cnt++;
          if (cap_ep_first < 0) cap_ep_first = cap_got;
        end
        last = cyc;
        cap_got++;
      end
    end
    check("chip_count", cap_got, n);
  endtask

  function automatic logic [31:0] first_bits(input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r = {r[30:0], cap_chip[i]};
    return r;
  endfunction

  function automatic int gold_mism(input int n, input int off);
    int m;
    m = 0;
    for (int i = 0; i < n; i++)
      if (cap_chip[i] != gold[(i + off) % 1023]) m++;
    return m;
  endfunction

  // Drop enable, load a new config, then raise enable on a negedge.
  task automatic start(input int sat, input int phase);
    @(negedge clk_in);
    enable_in = 1'b0;
    repeat (2) @(negedge clk_in);
    n_sat_in    = 5'(sat);
    ca_phase_in = 16'(phase);
    enable_in   = 1'b1;
  endtask

  initial begin
    int act;

    // Reset state
    repeat (2) @(negedge clk_in);
    check("rst_outs", outs, 4'b0000);
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
    check("idle_outs", outs, 4'b0000);

    // PRN1, phase 0
    start(0, 0);
    capture(10);
    check("prn1_vld_rise", cap_vld_rise, 2);
    check("prn1_latency", cap_lat, 3);
    check("prn1_first10", first_bits(10), 32'b1100100000);
    check("prn1_epoch0", cap_ep_first, 0);
    check("prn1_gaps", cap_gap_bad, 0);

    // PRN2, phase 0: full period plus one chip to see the epoch repeat
    start(1, 0);
    capture(1024);
    build_gold(1);
    check("prn2_latency", cap_lat, 3);
    check("prn2_first10", first_bits(10), 32'b1110010000);
    check("prn2_epoch_first", cap_ep_first, 0);
    check("prn2_epoch_cnt", cap_ep_cnt, 2);
    check("prn2_epoch_last", cap_chip[1023] == cap_chip[0] && cap_ep_cnt == 2, 1);
    check("prn2_gaps", cap_gap_bad, 0);
    check("prn2_gold", gold_mism(1023, 0), 0);

    // PRN1, phase 3
    start(0, 3);
    capture(1021);
    build_gold(0);
    check("ph3_vld_rise", cap_vld_rise, 5);
    check("ph3_latency", cap_lat, 6);
    check("ph3_first_chip", cap_chip[0], 1'b0);
    check("ph3_epoch_idx", cap_ep_first, 1020);
    check("ph3_gaps", cap_gap_bad, 0);
    check("ph3_gold", gold_mism(1021, 3), 0);

    // Satellite change mid-RUN: slew again, then PRN32 from chip 3
    n_sat_in = 5'd31;
    @(negedge clk_in);
    check("resat_vld_drop", code_valid_out, 1'b0);
    capture(1023);
    build_gold(31);
    check("resat_vld_rise", cap_vld_rise, 4);
    check("resat_latency", cap_lat, 5);
    check("resat_hand7", first_bits(7), 32'b1001010);
    check("resat_epoch_idx", cap_ep_first, 1020);
    check("resat_gold", gold_mism(1023, 3), 0);

    // Enable drop during a 1000-chip slew
    start(0, 1000);
    act = 0;
    repeat (500) begin
      @(negedge clk_in);
      if (chip_strobe_out || code_valid_out) act++;
    end
    check("slew_quiet", act, 0);
    enable_in = 1'b0;
    @(negedge clk_in);
    check("slew_abort_outs", outs, 4'b0000);
    @(negedge clk_in);
    enable_in = 1'b1;
    capture(25);
    build_gold(0);
    check("restart_vld_rise", cap_vld_rise, 1002);
    check("restart_latency", cap_lat, 1003);
    check("restart_epoch_idx", cap_ep_first, 23);
    check("restart_gold", gold_mism(25, 1000), 0);

    // Async reset mid-RUN
    check("pre_rst_vld", code_valid_out, 1'b1);
    #2;
    rst_in = 1'b1;
    #1;
    check("async_rst_outs", outs, 4'b0000);
    @(negedge clk_in);
    rst_in = 1'b0;
    act = 0;
    repeat (100) begin
      @(negedge clk_in);
      if (chip_strobe_out || code_valid_out) act++;
    end
    check("post_rst_quiet", act, 0);
    start(0, 0);
    capture(10);
    check("post_rst_latency", cap_lat, 3);
    check("post_rst_first10", first_bits(10), 32'b1100100000);

    // Phase 1023 aliases to chip 0
    start(1, 1023);
    capture(3);
    check("ph1023_latency", cap_lat, 3);
    check("ph1023_first3", first_bits(3), 32'b111);
    check("ph1023_epoch", cap_ep_first, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
